// File: rtl/complete_arbiter.sv
// Round-robin arbiter sharing the single completion broadcast (regfile write
// port + rename pending-clear) among p_num_pipes execute pipes.

// Per-pipe slice: flags a request at or above the current priority pointer.
module complete_arbiter_lane #(
  parameter int IDX = 0,
  parameter int PW  = 1
) (
  input  logic          val,
  input  logic [PW-1:0] prio,
  output logic          hi
);
  assign hi = val && (32'(prio) <= IDX);
endmodule

module complete_arbiter #(
  parameter int p_seq_num_bits  = 5,
  parameter int p_num_pipes     = 2,
  parameter int p_num_phys_regs = 36,
  localparam int p_phys_addr_bits = $clog2(p_num_phys_regs)
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [p_num_pipes-1:0]                           req_val,
  output logic [p_num_pipes-1:0]                           req_rdy,
  input  logic [p_num_pipes-1:0][p_seq_num_bits-1:0]       req_seq_num,
  input  logic [p_num_pipes-1:0][4:0]                      req_waddr,
  input  logic [p_num_pipes-1:0][p_phys_addr_bits-1:0]     req_preg,
  input  logic [p_num_pipes-1:0]                           req_wen,
  input  logic [p_num_pipes-1:0][31:0]                     req_wdata,
  output logic                                             complete_val,
  output logic [p_seq_num_bits-1:0]                        complete_seq_num,
  output logic [4:0]                                       complete_waddr,
  output logic [p_phys_addr_bits-1:0]                      complete_preg,
  output logic                                             complete_wen,
  output logic [31:0]                                      complete_wdata,
  output logic [15:0]                                      conflict_cnt
);
  localparam int PW = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

  logic [PW-1:0]          prio, nxt_prio, g;
  logic [p_num_pipes-1:0] hi;
  logic                   grant, multi;

  for (genvar i = 0; i < p_num_pipes; i++) begin : g_lane
    complete_arbiter_lane #(.IDX(i), .PW(PW)) u_lane (
      .val (req_val[i]),
      .prio(prio),
      .hi  (hi[i])
    );
  end

  // Winner: lowest request at/above prio, else lowest request overall (wrap).
  always_comb begin
    grant = |req_val;
    g     = '0;
    for (int i = p_num_pipes - 1; i >= 0; i--)
      if (req_val[i]) g = PW'(i);
    for (int i = p_num_pipes - 1; i >= 0; i--)
      if (hi[i]) g = PW'(i);
    nxt_prio = (32'(g) == p_num_pipes - 1) ? '0 : g + 1'b1;
    req_rdy  = '0;
    if (grant && !rst) req_rdy[g] = 1'b1;
  end

  // Two or more simultaneous requests: clearing the lowest set bit leaves one.
  assign multi = |(req_val & (req_val - 1'b1));

  // Pointer advance past the winner; held across idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        prio <= '0;
    else if (grant) prio <= nxt_prio;
  end

  // Output register: valid every granted cycle, payload held when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      complete_val     <= 1'b0;
      complete_seq_num <= '0;
      complete_waddr   <= '0;
      complete_preg    <= '0;
      complete_wen     <= 1'b0;
      complete_wdata   <= '0;
    end else begin
      complete_val <= grant;
      if (grant) begin
        complete_seq_num <= req_seq_num[g];
        complete_waddr   <= req_waddr[g];
        complete_preg    <= req_preg[g];
        complete_wen     <= req_wen[g];
        complete_wdata   <= req_wdata[g];
      end
    end
  end

  // Saturating count of contended cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                conflict_cnt <= '0;
    else if (multi && conflict_cnt != '1)   conflict_cnt <= conflict_cnt + 16'd1;
  end
endmodule

// File: tb/tb_complete_arbiter.sv
// Directed bench for complete_arbiter: N=2 main instance plus N=3 for wrap.
module tb_complete_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // N=2 instance
  logic [1:0]        req_val, req_rdy, req_wen;
  logic [1:0][4:0]   req_seq_num, req_waddr;
  logic [1:0][5:0]   req_preg;
  logic [1:0][31:0]  req_wdata;
  logic              c_val, c_wen;
  logic [4:0]        c_seq, c_waddr;
  logic [5:0]        c_preg;
  logic [31:0]       c_wdata;
  logic [15:0]       c_cnt;

  complete_arbiter #(.p_seq_num_bits(5), .p_num_pipes(2), .p_num_phys_regs(36)) dut (
    .clk(clk), .rst(rst), .req_val(req_val), .req_rdy(req_rdy),
    .req_seq_num(req_seq_num), .req_waddr(req_waddr), .req_preg(req_preg),
    .req_wen(req_wen), .req_wdata(req_wdata),
    .complete_val(c_val), .complete_seq_num(c_seq), .complete_waddr(c_waddr),
    .complete_preg(c_preg), .complete_wen(c_wen), .complete_wdata(c_wdata),
    .conflict_cnt(c_cnt)
  );

  // N=3 instance, fixed payload: pipe i carries seq 5+i
  logic [2:0]        v3, r3;
  logic [2:0][4:0]   seq3;
  logic [2:0][4:0]   waddr3;
  logic [2:0][5:0]   preg3;
  logic [2:0][31:0]  wdata3;
  logic [2:0]        wen3;
  logic              c3_val, c3_wen;
  logic [4:0]        c3_seq, c3_waddr;
  logic [5:0]        c3_preg;
  logic [31:0]       c3_wdata;
  logic [15:0]       c3_cnt;

  complete_arbiter #(.p_seq_num_bits(5), .p_num_pipes(3), .p_num_phys_regs(36)) dut3 (
    .clk(clk), .rst(rst), .req_val(v3), .req_rdy(r3),
    .req_seq_num(seq3), .req_waddr(waddr3), .req_preg(preg3),
    .req_wen(wen3), .req_wdata(wdata3),
    .complete_val(c3_val), .complete_seq_num(c3_seq), .complete_waddr(c3_waddr),
    .complete_preg(c3_preg), .complete_wen(c3_wen), .complete_wdata(c3_wdata),
    .conflict_cnt(c3_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int c0, c1;
  int exp_g [6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    req_val = '0; req_wen = '0; req_seq_num = '0; req_waddr = '0;
    req_preg = '0; req_wdata = '0;
    v3 = '0; seq3 = {5'd7, 5'd6, 5'd5}; waddr3 = '0; preg3 = '0; wdata3 = '0; wen3 = '0;

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("rst_val", 64'(c_val), 64'd0);
    chk("rst_cnt", 64'(c_cnt), 64'd0);
    chk("rst_preg", 64'(c_preg), 64'd0);
    req_val = 2'b11;
    #1;
    chk("rst_rdy", 64'(req_rdy), 64'd0);
    req_val = 2'b00;
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_val", 64'(c_val), 64'd0);
      chk("idle_rdy", 64'(req_rdy), 64'd0);
      chk("idle_cnt", 64'(c_cnt), 64'd0);
    end

    // Single requester on pipe 1
    req_val = 2'b10; req_seq_num[1] = 5'd3; req_preg[1] = 6'd12;
    req_wdata[1] = 32'hDEADBEEF; req_wen[1] = 1'b1; req_waddr[1] = 5'd7;
    #1 chk("single_rdy", 64'(req_rdy), 64'b10);
    tick();
    req_val = 2'b00;
    chk("single_val", 64'(c_val), 64'd1);
    chk("single_preg", 64'(c_preg), 64'd12);
    chk("single_wdata", 64'(c_wdata), 64'hDEADBEEF);
    chk("single_seq", 64'(c_seq), 64'd3);
    chk("single_wen", 64'(c_wen), 64'd1);
    chk("single_waddr", 64'(c_waddr), 64'd7);
    tick();
    chk("single_drop", 64'(c_val), 64'd0);
    chk("single_hold", 64'(c_preg), 64'd12);

    // Both pipes with 3 queued completions each (prio back at 0)
    c0 = 3; c1 = 3;
    for (int c = 0; c < 6; c++) begin
      req_val = {c1 > 0, c0 > 0};
      req_seq_num[0] = 5'(10 + 3 - c0);
      req_seq_num[1] = 5'(20 + 3 - c1);
      #1 chk("rr_rdy", 64'(req_rdy), 64'(1 << exp_g[c]));
      if (req_rdy[0]) c0--;
      if (req_rdy[1]) c1--;
      tick();
      chk("rr_val", 64'(c_val), 64'd1);
      chk("rr_seq", 64'(c_seq), 64'(10 * (exp_g[c] + 1) + c / 2));
    end
    req_val = 2'b00;
    chk("rr_conflict", 64'(c_cnt), 64'd5);

    // Pointer retention across idle cycles
    req_val = 2'b01; req_seq_num[0] = 5'd1; req_seq_num[1] = 5'd2;
    #1 chk("ret_rdy0", 64'(req_rdy), 64'b01);
    tick();
    req_val = 2'b00;
    tick();
    tick();
    req_val = 2'b11;
    #1 chk("ret_rdy1", 64'(req_rdy), 64'b10);
    tick();
    chk("ret_seq", 64'(c_seq), 64'd2);
    req_val = 2'b00;

    // N=3 wrap: grant pipe 1 to set prio=2, then 011 wraps to pipe 0
    v3 = 3'b010;
    #1 chk("w3_rdy1", 64'(r3), 64'b010);
    tick();
    v3 = 3'b011;
    #1 chk("w3_wrap", 64'(r3), 64'b001);
    tick();
    chk("w3_seq", 64'(c3_seq), 64'd5);
    #1 chk("w3_prio1", 64'(r3), 64'b010);
    tick();
    v3 = 3'b000;

    // Reset mid-transfer drops the completion immediately
    req_val = 2'b01;
    tick();
    chk("mid_pre", 64'(c_val), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_val", 64'(c_val), 64'd0);
    chk("mid_rdy", 64'(req_rdy), 64'd0);
    chk("mid_cnt", 64'(c_cnt), 64'd0);

    // Saturation of conflict counter
    req_val = 2'b11;
    #1 rst = 1'b0;
    repeat (65534) @(posedge clk);
    #1 chk("sat_fffe", 64'(c_cnt), 64'hFFFE);
    tick();
    chk("sat_ffff", 64'(c_cnt), 64'hFFFF);
    repeat (5) @(posedge clk);
    #1 chk("sat_hold", 64'(c_cnt), 64'hFFFF);
    req_val = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
